// File: rtl/dmem_arbiter_if.sv
// Shared data_mem port bundle: two requester channels plus the data_mem side.
// Requesters and data_mem model sit on the master modport; the arbiter is the slave.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic              p0_req;
    logic              p0_we;
    logic [1:0]        p0_store_type;
    logic [2:0]        p0_load_type;
    logic [ADDR_W-1:0] p0_addr;
    logic [31:0]       p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [31:0]       p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [1:0]        p1_store_type;
    logic [2:0]        p1_load_type;
    logic [ADDR_W-1:0] p1_addr;
    logic [31:0]       p1_wdata;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [31:0]       p1_rdata;

    logic              mem_write;
    logic [1:0]        mem_store_type;
    logic [2:0]        mem_load_type;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  p0_req, p0_we, p0_store_type, p0_load_type, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        input  p1_req, p1_we, p1_store_type, p1_load_type, p1_addr, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_write, mem_store_type, mem_load_type, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output p0_req, p0_we, p0_store_type, p0_load_type, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        output p1_req, p1_we, p1_store_type, p1_load_type, p1_addr, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  mem_write, mem_store_type, mem_load_type, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data_mem arbiter, port 0 fixed priority with port 1 anti-starvation; combinational grant,
// load data returned 1 cycle after grant; a denied requester simply holds its request.
module dmem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0]  starve_cnt;
    logic              starve;
    logic              p0_gnt;
    logic              p1_gnt;
    logic              sel_we;
    logic [1:0]        sel_store_type;
    logic [2:0]        sel_load_type;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              rd_pend;
    logic              rd_owner;

    assign starve = (starve_cnt == CNT_W'(STARVE_MAX));

    // Grants are killed during reset so nothing reaches data_mem.
    assign p1_gnt = ~rst & bus.p1_req & (~bus.p0_req | starve);
    assign p0_gnt = ~rst & bus.p0_req & ~p1_gnt;

    always_comb begin
        sel_we         = 1'b0;
        sel_store_type = 2'b00;
        sel_load_type  = 3'b000;
        sel_addr       = '0;
        sel_wdata      = 32'h0;
        if (p1_gnt) begin
            sel_we         = bus.p1_we;
            sel_store_type = bus.p1_store_type;
            sel_load_type  = bus.p1_load_type;
            sel_addr       = bus.p1_addr;
            sel_wdata      = bus.p1_wdata;
        end else if (p0_gnt) begin
            sel_we         = bus.p0_we;
            sel_store_type = bus.p0_store_type;
            sel_load_type  = bus.p0_load_type;
            sel_addr       = bus.p0_addr;
            sel_wdata      = bus.p0_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            rd_pend    <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            if (bus.p1_req & ~p1_gnt) begin
                if (!starve) starve_cnt <= starve_cnt + CNT_W'(1);
            end else begin
                starve_cnt <= '0;
            end
            rd_pend  <= (p0_gnt | p1_gnt) & ~sel_we;
            rd_owner <= p1_gnt;
        end
    end

    assign bus.p0_gnt         = p0_gnt;
    assign bus.p1_gnt         = p1_gnt;
    assign bus.mem_write      = sel_we;
    assign bus.mem_store_type = sel_store_type;
    assign bus.mem_load_type  = sel_load_type;
    assign bus.mem_addr       = sel_addr;
    assign bus.mem_wdata      = sel_wdata;

    assign bus.p0_rvalid = rd_pend & ~rd_owner;
    assign bus.p1_rvalid = rd_pend &  rd_owner;
    assign bus.p0_rdata  = bus.p0_rvalid ? bus.mem_rdata : 32'h0;
    assign bus.p1_rdata  = bus.p1_rvalid ? bus.mem_rdata : 32'h0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1 KB data_mem behind it.
// Each vector: inputs for one cycle, expected grant/mux outputs, expected response after the edge.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(12)) bus ();

    dmem_arbiter #(.ADDR_W(12), .STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // data_mem model: byte-enable write, sync read with load formatting
    logic [7:0] mem [0:1023];

    function automatic logic [31:0] fmt(input logic [2:0] lt, input logic [9:0] a);
        logic [9:0] a1, a2, a3;
        logic [7:0] b;
        logic [15:0] h;
        a1 = a + 10'd1; a2 = a + 10'd2; a3 = a + 10'd3;
        b = mem[a];
        h = {mem[a1], mem[a]};
        case (lt)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return {mem[a3], mem[a2], mem[a1], mem[a]};
            3'b011:  return {24'h0, b};
            3'b100:  return {16'h0, h};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [9:0] a;
        a = bus.mem_addr[9:0];
        if (bus.mem_write) begin
            mem[a] <= bus.mem_wdata[7:0];
            if (bus.mem_store_type != 2'b00) mem[a + 10'd1] <= bus.mem_wdata[15:8];
            if (bus.mem_store_type == 2'b10) begin
                mem[a + 10'd2] <= bus.mem_wdata[23:16];
                mem[a + 10'd3] <= bus.mem_wdata[31:24];
            end
        end
        bus.mem_rdata <= fmt(bus.mem_load_type, a);
    end

    typedef struct {
        logic        rst;
        logic        r0, we0;
        logic [1:0]  st0;
        logic [2:0]  lt0;
        logic [11:0] a0;
        logic [31:0] d0;
        logic        r1, we1;
        logic [1:0]  st1;
        logic [2:0]  lt1;
        logic [11:0] a1;
        logic [31:0] d1;
        logic        eg0, eg1, ew;
        logic [11:0] ea;
        logic        ev0;
        logic [31:0] ed0;
        logic        ev1;
        logic [31:0] ed1;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic r0, input logic we0, input logic [1:0] st0, input logic [2:0] lt0,
        input logic [11:0] a0, input logic [31:0] d0,
        input logic r1, input logic we1, input logic [1:0] st1, input logic [2:0] lt1,
        input logic [11:0] a1, input logic [31:0] d1,
        input logic eg0, input logic eg1, input logic ew, input logic [11:0] ea,
        input logic ev0, input logic [31:0] ed0, input logic ev1, input logic [31:0] ed1);
        vec_t v;
        v.rst = r;
        v.r0 = r0; v.we0 = we0; v.st0 = st0; v.lt0 = lt0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.we1 = we1; v.st1 = st1; v.lt1 = lt1; v.a1 = a1; v.d1 = d1;
        v.eg0 = eg0; v.eg1 = eg1; v.ew = ew; v.ea = ea;
        v.ev0 = ev0; v.ed0 = ed0; v.ev1 = ev1; v.ed1 = ed1;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst               = v.rst;
        bus.p0_req        = v.r0;  bus.p0_we = v.we0; bus.p0_store_type = v.st0;
        bus.p0_load_type  = v.lt0; bus.p0_addr = v.a0; bus.p0_wdata = v.d0;
        bus.p1_req        = v.r1;  bus.p1_we = v.we1; bus.p1_store_type = v.st1;
        bus.p1_load_type  = v.lt1; bus.p1_addr = v.a1; bus.p1_wdata = v.d1;
        #1;
        chk("p0_gnt",    idx, 32'(bus.p0_gnt),    32'(v.eg0));
        chk("p1_gnt",    idx, 32'(bus.p1_gnt),    32'(v.eg1));
        chk("mem_write", idx, 32'(bus.mem_write), 32'(v.ew));
        chk("mem_addr",  idx, 32'(bus.mem_addr),  32'(v.ea));
        @(posedge clk);
        #1;
        chk("p0_rvalid", idx, 32'(bus.p0_rvalid), 32'(v.ev0));
        chk("p1_rvalid", idx, 32'(bus.p1_rvalid), 32'(v.ev1));
        chk("p0_rdata",  idx, bus.p0_rdata, v.ed0);
        chk("p1_rdata",  idx, bus.p1_rdata, v.ed1);
    endtask

    localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b011, LHU = 3'b100;

    initial begin
        vec_t tbl[$];
        vec_t v;
        logic g1;

        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_store_type = SB; bus.p0_load_type = LB;
        bus.p0_addr = '0;  bus.p0_wdata = '0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_store_type = SB; bus.p1_load_type = LB;
        bus.p1_addr = '0;  bus.p1_wdata = '0;

        // reset: both requesting, nothing granted
        tbl.push_back(mk(1, 1,1,SW,LW,12'h00C,32'hDEADBEEF, 1,0,SB,LW,12'h020,0, 0,0,0,12'h000, 0,0, 0,0));
        tbl.push_back(mk(1, 1,1,SW,LW,12'h00C,32'hDEADBEEF, 1,0,SB,LW,12'h020,0, 0,0,0,12'h000, 0,0, 0,0));
        // p0 store word then load it back
        tbl.push_back(mk(0, 1,1,SW,LB,12'h00C,32'hDEADBEEF, 0,0,SB,LB,0,0, 1,0,1,12'h00C, 0,0, 0,0));
        tbl.push_back(mk(0, 1,0,SB,LW,12'h00C,0, 0,0,SB,LB,0,0, 1,0,0,12'h00C, 1,32'hDEADBEEF, 0,0));
        // p1 byte store, signed and unsigned byte loads
        tbl.push_back(mk(0, 0,0,SB,LB,0,0, 1,1,SB,LB,12'h00D,32'h00000080, 0,1,1,12'h00D, 0,0, 0,0));
        tbl.push_back(mk(0, 0,0,SB,LB,0,0, 1,0,SB,LB,12'h00D,0, 0,1,0,12'h00D, 0,0, 1,32'hFFFFFF80));
        tbl.push_back(mk(0, 0,0,SB,LB,0,0, 1,0,SB,LBU,12'h00D,0, 0,1,0,12'h00D, 0,0, 1,32'h00000080));
        // merged word and halfword loads from p0
        tbl.push_back(mk(0, 1,0,SB,LW,12'h00C,0, 0,0,SB,LB,0,0, 1,0,0,12'h00C, 1,32'hDEAD80EF, 0,0));
        tbl.push_back(mk(0, 1,0,SB,LH,12'h00E,0, 0,0,SB,LB,0,0, 1,0,0,12'h00E, 1,32'hFFFFDEAD, 0,0));
        tbl.push_back(mk(0, 1,0,SB,LHU,12'h00C,0, 0,0,SB,LB,0,0, 1,0,0,12'h00C, 1,32'h000080EF, 0,0));
        // p0 halfword store, read back by p1
        tbl.push_back(mk(0, 1,1,SH,LB,12'h030,32'h12348001, 0,0,SB,LB,0,0, 1,0,1,12'h030, 0,0, 0,0));
        tbl.push_back(mk(0, 0,0,SB,LB,0,0, 1,0,SB,LW,12'h030,0, 0,1,0,12'h030, 0,0, 1,32'h00008001));
        tbl.push_back(mk(0, 0,0,SB,LB,0,0, 1,0,SB,LH,12'h030,0, 0,1,0,12'h030, 0,0, 1,32'hFFFF8001));
        // seed 0x010 / 0x020
        tbl.push_back(mk(0, 1,1,SW,LB,12'h010,32'h11223344, 0,0,SB,LB,0,0, 1,0,1,12'h010, 0,0, 0,0));
        tbl.push_back(mk(0, 0,0,SB,LB,0,0, 1,1,SW,LB,12'h020,32'h55667788, 0,1,1,12'h020, 0,0, 0,0));
        // simultaneous: p0 wins, p1 held then served
        tbl.push_back(mk(0, 1,0,SB,LW,12'h010,0, 1,0,SB,LW,12'h020,0, 1,0,0,12'h010, 1,32'h11223344, 0,0));
        tbl.push_back(mk(0, 0,0,SB,LB,0,0, 1,0,SB,LW,12'h020,0, 0,1,0,12'h020, 0,0, 1,32'h55667788));
        // alternating back-to-back loads
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0)
                tbl.push_back(mk(0, 1,0,SB,LW,12'h010,0, 0,0,SB,LB,0,0, 1,0,0,12'h010, 1,32'h11223344, 0,0));
            else
                tbl.push_back(mk(0, 0,0,SB,LB,0,0, 1,0,SB,LW,12'h020,0, 0,1,0,12'h020, 0,0, 1,32'h55667788));
        end
        // idle
        tbl.push_back(mk(0, 0,0,SB,LB,0,0, 0,0,SB,LB,0,0, 0,0,0,12'h000, 0,0, 0,0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // starvation: both held, p1 wins every 5th cycle
        for (int i = 0; i < 10; i++) begin
            g1 = (i % 5 == 4);
            v = mk(0, 1,0,SB,LW,12'h010,0, 1,0,SB,LW,12'h020,0,
                   !g1, g1, 0, g1 ? 12'h020 : 12'h010,
                   !g1, g1 ? 32'h0 : 32'h11223344, g1, g1 ? 32'h55667788 : 32'h0);
            apply(v, 100 + i);
        end

        // build up starvation count, then reset with a p1 load pending
        for (int i = 0; i < 3; i++)
            apply(mk(0, 1,0,SB,LW,12'h010,0, 1,0,SB,LW,12'h020,0, 1,0,0,12'h010, 1,32'h11223344, 0,0), 200 + i);
        for (int i = 0; i < 2; i++)
            apply(mk(1, 0,0,SB,LB,0,0, 1,0,SB,LW,12'h020,0, 0,0,0,12'h000, 0,0, 0,0), 210 + i);
        // count must restart from zero: four p0 grants before p1
        for (int i = 0; i < 5; i++) begin
            g1 = (i == 4);
            v = mk(0, 1,0,SB,LW,12'h010,0, 1,0,SB,LW,12'h020,0,
                   !g1, g1, 0, g1 ? 12'h020 : 12'h010,
                   !g1, g1 ? 32'h0 : 32'h11223344, g1, g1 ? 32'h55667788 : 32'h0);
            apply(v, 220 + i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
